// File: rtl/muldiv_seq.sv
// Sequential 32-bit unsigned multiply (shift-add) and divide (restoring).
// All 32-bit add/sub work goes through an external add/sub unit on the as_* port.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic        as_add,
    output logic [31:0] as_num1,
    output logic [31:0] as_num2,
    input  logic [31:0] as_result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        dbz_q, dbz_d;

    logic        accept, dz, carry, borrow;
    logic [31:0] t;

    assign accept = (state_q == IDLE) && start;
    assign dz     = op && (b == 32'd0);
    // Divide step operand: remainder shifted left, next dividend bit shifted in.
    assign t      = {acc_hi_q[30:0], acc_lo_q[31]};
    assign carry  = (acc_hi_q[31] & a_q[31]) |
                    ((acc_hi_q[31] | a_q[31]) & ~as_result[31]);
    assign borrow = ~acc_hi_q[31] &
                    ((~t[31] & b_q[31]) |
                     (~(t[31] ^ b_q[31]) & as_result[31]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = dz ? DONE : RUN;
            RUN:     if (cnt_q == 5'd31) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        as_add  = 1'b1;
        as_num1 = 32'd0;
        as_num2 = 32'd0;
        if (state_q == RUN) begin
            if (op_q) begin
                as_add  = 1'b0;
                as_num1 = t;
                as_num2 = b_q;
            end else begin
                as_num1 = acc_hi_q;
                as_num2 = a_q;
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        if (accept) begin
            op_d     = op;
            a_d      = a;
            b_d      = b;
            cnt_d    = 5'd0;
            acc_hi_d = 32'd0;
            acc_lo_d = op ? a : b;
            dbz_d    = dz;
            if (dz) begin
                hi_d = a;
                lo_d = 32'hFFFF_FFFF;
            end
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 5'd1;
            if (op_q) begin
                acc_hi_d = borrow ? t : as_result;
                acc_lo_d = {acc_lo_q[30:0], ~borrow};
            end else if (acc_lo_q[0]) begin
                {acc_hi_d, acc_lo_d} = {carry, as_result, acc_lo_q[31:1]};
            end else begin
                {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[31:1]};
            end
            if (cnt_q == 5'd31) begin
                hi_d = acc_hi_d;
                lo_d = acc_lo_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            op_q     <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural add/sub unit.
// Stimulus pushes expected results; a negedge monitor pops on each done.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero, as_add;
    logic [31:0] hi, lo, as_num1, as_num2, as_result;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero), .as_add(as_add),
        .as_num1(as_num1), .as_num2(as_num2), .as_result(as_result)
    );

    assign as_result = as_add ? as_num1 + as_num2 : as_num1 - as_num2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done with empty scoreboard (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] eh,
                         input logic [31:0] el, input logic ed,
                         input bit expect_done);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        if (expect_done) begin
            e.hi  = eh;
            e.lo  = el;
            e.dbz = ed;
            e.cyc = cyc + ((o && bb == 32'd0) ? 1 : 33);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_as_add", {31'd0, as_add}, 32'd1);
        chk("rst_as_num1", as_num1, 32'd0);
        chk("rst_as_num2", as_num2, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b0;

        issue(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1);
        drain();
        chk("idle_as_add", {31'd0, as_add}, 32'd1);
        chk("idle_as_num1", as_num1, 32'd0);
        chk("idle_as_num2", as_num2, 32'd0);

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
        drain();
        issue(1'b0, 32'h0001_0000, 32'h0001_0000,
              32'd1, 32'd0, 1'b0, 1);
        drain();
        issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
        drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        drain();
        issue(1'b1, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 1);
        drain();
        issue(1'b1, 32'h8000_0000, 32'd3, 32'd2, 32'd715827882, 1'b0, 1);
        drain();
        issue(1'b1, 32'hDEAD_BEEF, 32'h10, 32'hF, 32'h0DEA_DBEE, 1'b0, 1);
        drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001,
              32'h7FFF_FFFE, 32'd1, 1'b0, 1);
        drain();

        issue(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
        drain();
        issue(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1);
        drain();

        // Second start mid-RUN must be dropped.
        issue(1'b0, 32'd12345, 32'd1000, 32'd0, 32'd12345000, 1'b0, 1);
        repeat (8) @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd99;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset in the middle of a multiply: no done, outputs cleared.
        issue(1'b0, 32'hFFFF, 32'hFFFF, 32'd0, 32'd0, 1'b0, 0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset();
        repeat (3) @(negedge clk);
        chk("rst_hold_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        issue(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1);
        drain();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
